// File: rtl/ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ascon_ctrl_fsm
// Purpose  : Sequencing controller for an ASCON-128 encryption datapath.
//            Walks initialisation, associated-data, plaintext and
//            finalisation phases, runs one permutation round per clock,
//            drives the round index and every datapath enable, and
//            handshakes input blocks with the host.
// Ports    : clock_i, reset_i (sync, active-high)
//            start_i            - start a message (sampled in IDLE only)
//            data_valid_i       - host presents the current AD/PT block
//            data_ready_o       - block accepted this cycle when valid
//            init_sel_o         - load IV||K||N into the state register
//            ena_state_o        - state register write enable
//            round_o[3:0]       - round constant index 0..11
//            ena_xor_up_o       - XOR data block into state word 0
//            ena_xor_key_lsb_o  - XOR 0..0||K after init permutation
//            ena_xor_dom_o      - domain-separation XOR after last AD block
//            ena_xor_key_msb_o  - XOR K into words 1,2 before finalisation
//            ena_xor_key_tag_o  - XOR K into words 3,4 after finalisation
//            cipher_valid_o     - ciphertext block valid
//            tag_valid_o        - tag valid (DONE)
//            blk_cnt_o[3:0]     - block index within the current phase
//            busy_o             - high outside IDLE
//            done_o             - one-cycle end-of-message pulse
// Options  : ASCON_DECRYPT_EN adds decrypt_i (latched at start) and
//            ena_replace_o (overwrite state word 0 with ciphertext input).
// Revision : 1.0 - initial release
// ============================================================================
module ascon_ctrl_fsm #(
    parameter int NB_AD = 1,   // AD blocks per message, 1..15
    parameter int NB_PT = 4    // PT blocks per message, 1..15
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
`ifdef ASCON_DECRYPT_EN
    input  logic       decrypt_i,
    output logic       ena_replace_o,
`endif
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       init_sel_o,
    output logic       ena_state_o,
    output logic [3:0] round_o,
    output logic       ena_xor_up_o,
    output logic       ena_xor_key_lsb_o,
    output logic       ena_xor_dom_o,
    output logic       ena_xor_key_msb_o,
    output logic       ena_xor_key_tag_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic [3:0] blk_cnt_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] LAST_ROUND = 4'd11;
    localparam logic [3:0] PB_FIRST   = 4'd6;   // p^6 starts at round index 6
    localparam logic [3:0] LAST_AD    = 4'(NB_AD - 1);
    localparam logic [3:0] LAST_PT    = 4'(NB_PT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD_PERM = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT_PERM = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] blk_cnt_q, blk_cnt_d;
    logic       w_last_round;
    logic       w_accept;

    assign w_last_round = (round_q == LAST_ROUND);
    assign w_accept     = data_valid_i &&
                          ((state_q == S_WAIT_AD) || (state_q == S_WAIT_PT));

    // Next-state, round and block counter.  The round index holds its value
    // in the WAIT states so that a stalled host sees it frozen.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        blk_cnt_d = blk_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_INIT;
                    round_d   = 4'd0;
                    blk_cnt_d = 4'd0;
                end
            end
            S_INIT: begin
                if (w_last_round) begin
                    state_d   = S_WAIT_AD;
                    blk_cnt_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_WAIT_AD: begin
                if (data_valid_i) begin
                    state_d = S_AD_PERM;
                    round_d = PB_FIRST;
                end
            end
            S_AD_PERM: begin
                if (w_last_round) begin
                    if (blk_cnt_q == LAST_AD) begin
                        state_d   = S_WAIT_PT;
                        blk_cnt_d = 4'd0;
                    end else begin
                        state_d   = S_WAIT_AD;
                        blk_cnt_d = blk_cnt_q + 4'd1;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_WAIT_PT: begin
                if (data_valid_i) begin
                    if (blk_cnt_q < LAST_PT) begin
                        state_d = S_PT_PERM;
                        round_d = PB_FIRST;
                    end else begin
                        state_d = S_FINAL;
                        round_d = 4'd0;
                    end
                end
            end
            S_PT_PERM: begin
                if (w_last_round) begin
                    state_d   = S_WAIT_PT;
                    blk_cnt_d = blk_cnt_q + 4'd1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FINAL: begin
                if (w_last_round) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                round_d   = 4'd0;
                blk_cnt_d = 4'd0;
            end
            default: begin
                state_d   = S_IDLE;
                round_d   = 4'd0;
                blk_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            blk_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

`ifdef ASCON_DECRYPT_EN
    logic decrypt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            decrypt_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            decrypt_q <= decrypt_i;
        end
    end

    // In decrypt mode the ciphertext replaces word 0 rather than being XORed.
    assign ena_replace_o = decrypt_q && w_accept && (state_q == S_WAIT_PT);
`endif

    // Datapath enables decoded from state, round and the host handshake.
    always_comb begin
        init_sel_o        = 1'b0;
        ena_state_o       = 1'b0;
        ena_xor_up_o      = 1'b0;
        ena_xor_key_lsb_o = 1'b0;
        ena_xor_dom_o     = 1'b0;
        ena_xor_key_msb_o = 1'b0;
        ena_xor_key_tag_o = 1'b0;
        cipher_valid_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                init_sel_o  = start_i;
                ena_state_o = start_i;
            end
            S_INIT: begin
                ena_state_o       = 1'b1;
                ena_xor_key_lsb_o = w_last_round;
            end
            S_WAIT_AD: begin
                ena_state_o  = w_accept;
                ena_xor_up_o = w_accept;
            end
            S_AD_PERM: begin
                ena_state_o   = 1'b1;
                ena_xor_dom_o = w_last_round && (blk_cnt_q == LAST_AD);
            end
            S_WAIT_PT: begin
                ena_state_o       = w_accept;
                ena_xor_up_o      = w_accept;
                cipher_valid_o    = w_accept;
                ena_xor_key_msb_o = w_accept && (blk_cnt_q >= LAST_PT);
            end
            S_PT_PERM: begin
                ena_state_o = 1'b1;
            end
            S_FINAL: begin
                ena_state_o       = 1'b1;
                ena_xor_key_tag_o = w_last_round;
            end
            default: begin
                ena_state_o = 1'b0;
            end
        endcase
    end

    assign data_ready_o = (state_q == S_WAIT_AD) || (state_q == S_WAIT_PT);
    assign round_o      = round_q;
    assign blk_cnt_o    = blk_cnt_q;
    assign tag_valid_o  = (state_q == S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_ctrl_fsm
// Purpose  : Self-checking bench for ascon_ctrl_fsm.  Each message is
//            expanded into a per-cycle expected trace built phase by phase
//            (start, 12 init rounds, per-block wait/accept/6 rounds,
//            12 final rounds, done) with random host stalls and random
//            ignored start/valid pulses.
// Options  : ASCON_DECRYPT_EN connects decrypt_i / ena_replace_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_ctrl_fsm;

    localparam int NB_AD = 1;
    localparam int NB_PT = 4;

    logic       clock_i = 1'b0;
    logic       reset_i, start_i, data_valid_i, decrypt_i;
    logic       data_ready_o, init_sel_o, ena_state_o, ena_xor_up_o;
    logic       ena_xor_key_lsb_o, ena_xor_dom_o, ena_xor_key_msb_o;
    logic       ena_xor_key_tag_o, cipher_valid_o, tag_valid_o;
    logic       busy_o, done_o, ena_replace_o;
    logic [3:0] round_o, blk_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    ascon_ctrl_fsm #(.NB_AD(NB_AD), .NB_PT(NB_PT)) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .start_i           (start_i),
`ifdef ASCON_DECRYPT_EN
        .decrypt_i         (decrypt_i),
        .ena_replace_o     (ena_replace_o),
`endif
        .data_valid_i      (data_valid_i),
        .data_ready_o      (data_ready_o),
        .init_sel_o        (init_sel_o),
        .ena_state_o       (ena_state_o),
        .round_o           (round_o),
        .ena_xor_up_o      (ena_xor_up_o),
        .ena_xor_key_lsb_o (ena_xor_key_lsb_o),
        .ena_xor_dom_o     (ena_xor_dom_o),
        .ena_xor_key_msb_o (ena_xor_key_msb_o),
        .ena_xor_key_tag_o (ena_xor_key_tag_o),
        .cipher_valid_o    (cipher_valid_o),
        .tag_valid_o       (tag_valid_o),
        .blk_cnt_o         (blk_cnt_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

`ifndef ASCON_DECRYPT_EN
    assign ena_replace_o = 1'b0;
`endif

    // One expected cycle: inputs to drive plus outputs required.
    // rnd/blk of -1 mean "not checked this cycle".
    typedef struct {
        bit vld, st, dcr;
        bit rdy, init, est, up, klsb, dom, kmsb, ktag, cv, tv, busy, done, rep;
        int rnd;
        int blk;
    } rec_t;

    rec_t tr[$];

    function automatic rec_t busy_rec();
        rec_t r;
        r      = '{default: 0};
        r.vld  = 1'($urandom);
        r.st   = 1'($urandom);
        r.dcr  = 1'($urandom);
        r.busy = 1'b1;
        r.rnd  = -1;
        r.blk  = -1;
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r     = '{default: 0};
        r.vld = 1'($urandom);
        r.dcr = 1'($urandom);
        r.rnd = 0;
        r.blk = 0;
        return r;
    endfunction

    // Expand one message into the expected trace.
    task automatic build(input int stall_blk, input int stall_len,
                         input bit rnd_stalls, input bit dec_in);
        rec_t r;
        int   k;
        bit   dec;
`ifdef ASCON_DECRYPT_EN
        dec = dec_in;
`else
        dec = 1'b0;
`endif
        r = idle_rec(); r.st = 1; r.dcr = dec_in; r.init = 1; r.est = 1;
        tr.push_back(r);
        for (int rr = 0; rr < 12; rr++) begin
            r = busy_rec(); r.est = 1; r.rnd = rr; r.blk = 0; r.klsb = (rr == 11);
            tr.push_back(r);
        end
        for (int b = 0; b < NB_AD; b++) begin
            k = rnd_stalls ? int'($urandom_range(0, 3)) : 0;
            repeat (k) begin
                r = busy_rec(); r.vld = 0; r.rdy = 1; r.blk = b;
                tr.push_back(r);
            end
            r = busy_rec(); r.vld = 1; r.rdy = 1; r.up = 1; r.est = 1; r.blk = b;
            tr.push_back(r);
            for (int rr = 6; rr < 12; rr++) begin
                r = busy_rec(); r.est = 1; r.rnd = rr; r.blk = b;
                if (rr == 8) r.st = 1;
                r.dom = (rr == 11) && (b == NB_AD - 1);
                tr.push_back(r);
            end
        end
        for (int b = 0; b < NB_PT; b++) begin
            k = (b == stall_blk) ? stall_len :
                (rnd_stalls ? int'($urandom_range(0, 3)) : 0);
            repeat (k) begin
                r = busy_rec(); r.vld = 0; r.rdy = 1; r.blk = b;
                tr.push_back(r);
            end
            r = busy_rec(); r.vld = 1; r.rdy = 1; r.up = 1; r.est = 1; r.cv = 1;
            r.rep = dec; r.blk = b; r.kmsb = (b == NB_PT - 1);
            tr.push_back(r);
            if (b < NB_PT - 1) begin
                for (int rr = 6; rr < 12; rr++) begin
                    r = busy_rec(); r.est = 1; r.rnd = rr; r.blk = b;
                    tr.push_back(r);
                end
            end
        end
        for (int rr = 0; rr < 12; rr++) begin
            r = busy_rec(); r.est = 1; r.rnd = rr; r.ktag = (rr == 11);
            tr.push_back(r);
        end
        r = busy_rec(); r.st = 1; r.tv = 1; r.done = 1;
        tr.push_back(r);
        tr.push_back(idle_rec());
    endtask

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic apply(input rec_t r, input bit rst, input int idx);
        @(negedge clock_i);
        start_i      = r.st;
        data_valid_i = r.vld;
        decrypt_i    = r.dcr;
        reset_i      = rst;
        #1;
        chk("flags", idx,
            32'({data_ready_o, init_sel_o, ena_state_o, ena_xor_up_o,
                 ena_xor_key_lsb_o, ena_xor_dom_o, ena_xor_key_msb_o,
                 ena_xor_key_tag_o, cipher_valid_o, tag_valid_o,
                 busy_o, done_o, ena_replace_o}),
            32'({r.rdy, r.init, r.est, r.up, r.klsb, r.dom, r.kmsb,
                 r.ktag, r.cv, r.tv, r.busy, r.done, r.rep}));
        if (r.rnd >= 0) chk("round", idx, 32'(round_o), r.rnd);
        if (r.blk >= 0) chk("blk_cnt", idx, 32'(blk_cnt_o), r.blk);
    endtask

    // Play the trace; index equals cycle number relative to the start cycle.
    // abort_at >= 0 asserts reset in that cycle and expects IDLE next cycle.
    task automatic run(input int abort_at);
        for (int i = 0; i < tr.size(); i++) begin
            apply(tr[i], (i == abort_at), i);
            if (i == abort_at) begin
                apply(idle_rec(), 1'b0, i + 1);
                break;
            end
        end
        tr.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        decrypt_i    = 1'b0;
        repeat (3) @(posedge clock_i);
        apply(idle_rec(), 1'b0, -1);
        apply(idle_rec(), 1'b0, -1);

        // Default run, valid always high: done at cycle 54.
        build(-1, 0, 1'b0, 1'b0);
        run(-1);
        // Five-cycle stall on PT block 1, decrypt requested.
        build(1, 5, 1'b0, 1'b1);
        run(-1);
        // Reset during PT permutation at cycle 30, then a fresh message.
        build(-1, 0, 1'b0, 1'b0);
        run(30);
        build(-1, 0, 1'b0, 1'b1);
        run(-1);
        // Random stalls and random decrypt selection.
        for (int m = 0; m < 6; m++) begin
            build(-1, 0, 1'b1, 1'($urandom));
            run(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Sequencing controller for the ASCON-128 encryption datapath: state register, round-based permutation, upstream data XOR and downstream key/domain XORs.
- Walks initialisation, associated data (AD), plaintext (PT) and finalisation phases.
- Drives the round counter and every datapath enable, and handshakes input blocks with the host.
- One block is processed at a time; the datapath runs one permutation round per clock.

Parameters:
- NB_AD, 1, number of 64-bit AD blocks per message (1..15).
- NB_PT, 4, number of 64-bit PT blocks per message (1..15).

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  start new message; sampled only in IDLE
- data_valid_i  in  1  host presents the current AD/PT block
- data_ready_o  out  1  controller accepts a block this cycle (WAIT_AD/WAIT_PT)
- init_sel_o  out  1  load IV||K||N into the state register
- ena_state_o  out  1  state register write enable
- round_o  out  4  round constant index, 0..11
- ena_xor_up_o  out  1  XOR data block into state word 0
- ena_xor_key_lsb_o  out  1  XOR 0..0||K into state after the init permutation
- ena_xor_dom_o  out  1  XOR domain-separation bit (LSB of word 4) after the last AD permutation
- ena_xor_key_msb_o  out  1  XOR K into words 1,2 before the final permutation
- ena_xor_key_tag_o  out  1  XOR K into words 3,4 after the final permutation (tag)
- cipher_valid_o  out  1  ciphertext block valid this cycle
- tag_valid_o  out  1  tag valid (DONE state)
- blk_cnt_o  out  4  index of the current block within its phase
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of message

Interface rule: one clock; reset is synchronous and active-high (clock_i, reset_i).

Behaviour:
- Reset: state=IDLE, round_o=0, blk_cnt_o=0; all enables, valids, busy_o and done_o are 0.
- Reset mid-operation aborts the message. Next cycle is IDLE with reset values.
- round_o and blk_cnt_o are registered. Enables are decoded combinationally from state, round_o and data_valid_i.
- Transitions:
  - IDLE: on start_i, assert init_sel_o and ena_state_o, set round=0, go INIT. Otherwise all outputs are 0.
  - INIT (12 cycles, round 0..11): ena_state_o=1 and round increments each cycle. At round 11, assert ena_xor_key_lsb_o and go WAIT_AD with blk_cnt=0.
  - WAIT_AD: data_ready_o=1. On data_valid_i, assert ena_xor_up_o and ena_state_o, set round=6, go AD_PERM. Without valid, hold with all enables 0.
  - AD_PERM (6 cycles, round 6..11): at round 11, if blk_cnt==NB_AD-1, assert ena_xor_dom_o, clear blk_cnt and go WAIT_PT. Else increment blk_cnt and go WAIT_AD.
  - WAIT_PT: data_ready_o=1. On data_valid_i, assert ena_xor_up_o, cipher_valid_o and ena_state_o.
    - If blk_cnt<NB_PT-1: round=6, go PT_PERM.
    - Else: also assert ena_xor_key_msb_o, round=0, go FINAL.
  - PT_PERM (6 cycles, round 6..11): at round 11, increment blk_cnt and go WAIT_PT.
  - FINAL (12 cycles, round 0..11): at round 11, assert ena_xor_key_tag_o and go DONE.
  - DONE (1 cycle): tag_valid_o=1, done_o=1, go IDLE.
- start_i outside IDLE is ignored.
- data_valid_i outside WAIT states is ignored; data_ready_o=0 there.
- start_i asserted in the DONE cycle is not accepted; it must be sampled in IDLE.
- Latency with data_valid_i held high: start accepted at cycle 0 → done_o at cycle 12+1+7·NB_AD−... computed as 12 + 7·NB_AD + 7·(NB_PT−1) + 1 + 12 + 1. Defaults give cycle 54.

Optional Feature:
- Macro: ASCON_DECRYPT_EN.
- When defined:
  - Adds port decrypt_i (in, 1), latched on start acceptance.
  - Adds port ena_replace_o (out, 1).
  - In WAIT_PT on data_valid_i with decrypt latched: ena_replace_o=1 together with ena_xor_up_o and cipher_valid_o, so state word 0 is overwritten by the ciphertext input.
- When not defined: neither port exists and the block is encrypt-only.
- Sequencing and timing are identical in both builds.

Test Plan:
- Reset, then pulse start_i, with valid held high (defaults) → INIT rounds 0..11 at cycles 1..12; ena_xor_key_lsb_o at cycle 12; done_o only at cycle 54; tag_valid_o=1 at 54.
- Same run, check enables → ena_xor_up_o at cycles 13,20,27,34,41; cipher_valid_o at 20,27,34,41; ena_xor_dom_o at 19; ena_xor_key_msb_o at 41; ena_xor_key_tag_o at 53.
- Stall: data_valid_i low for 5 cycles in WAIT_PT blk 1 → data_ready_o stays 1, all enables 0, round_o frozen; done_o delayed by exactly 5 cycles (cycle 59).
- start_i pulsed during AD_PERM and in the DONE cycle → ignored; blk_cnt_o and sequencing unchanged; busy_o falls only after DONE.
- reset_i asserted at cycle 30 → cycle 31 is IDLE, all outputs 0; a new start_i at cycle 32 reproduces the full default sequence from cycle 32.
- ASCON_DECRYPT_EN with decrypt_i=1 at start → ena_replace_o high at cycles 20,27,34,41, otherwise identical; with decrypt_i=0, ena_replace_o is never high.
